// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine between the register file and a
// variable-latency data memory using a req/ack handshake.
//
// Ports
//   clk, reset          clock (posedge), asynchronous active-low reset
//   ld_req, st_req      start a load / store; sampled only while busy=0
//   addr, st_data       access address and store byte
//   dst_ptr             load destination register (register 0 is never written)
//   busy                access in flight; the core must stall
//   done, err           one-cycle completion / timeout-or-illegal pulses
//   rf_di, rf_ptr_w     load data and pointer to the register-file write port
//   rf_we               register-file write enable, one cycle per load
//   mem_req, mem_wr     memory request and direction (1=write)
//   mem_addr, mem_wdata memory address and write data, stable during mem_req
//   mem_rdata, mem_ack  memory read data and completion
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_req,
    input  logic       st_req,
    input  logic [7:0] addr,
    input  logic [7:0] st_data,
    input  logic [4:0] dst_ptr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rf_di,
    output logic [4:0] rf_ptr_w,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WB
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [4:0]       ptr_q, ptr_d;
    logic [7:0]       rf_di_q, rf_di_d;
    logic [4:0]       rf_ptr_q, rf_ptr_d;
    logic             rf_we_q, rf_we_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ptr_q    <= '0;
            rf_di_q  <= '0;
            rf_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ptr_q    <= ptr_d;
            rf_di_q  <= rf_di_d;
            rf_ptr_q <= rf_ptr_d;
            rf_we_q  <= rf_we_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // done/err/rf_we are registered pulses: they appear in the cycle after the
    // deciding state, which gives store done at N+2 and load write-back at N+3.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ptr_d    = ptr_q;
        rf_di_d  = rf_di_q;
        rf_ptr_d = rf_ptr_q;
        rf_we_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ld_req || st_req) begin
                    addr_d  = addr;
                    wdata_d = st_data;
                    ptr_d   = dst_ptr;
                    wr_d    = st_req;             // simultaneous ld+st runs as a store
                    err_d   = ld_req && st_req;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    // ack takes priority over a timeout hit in the same cycle
                    if (wr_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rf_di_d = mem_rdata;
                        state_d = S_WB;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_ptr_d = ptr_q;
                rf_we_d  = (ptr_q != 5'd0);       // register 0 is hardwired zero
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_req   = (state_q == S_ACCESS);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rf_di     = rf_di_q;
    assign rf_ptr_w  = rf_ptr_q;
    assign rf_we     = rf_we_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO  = 16;
    localparam int WIN = TO + 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_req, st_req;
    logic [7:0] addr, st_data;
    logic [4:0] dst_ptr;
    logic       busy, done, err;
    logic [7:0] rf_di;
    logic [4:0] rf_ptr_w;
    logic       rf_we, mem_req, mem_wr;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .st_req    (st_req),
        .addr      (addr),
        .st_data   (st_data),
        .dst_ptr   (dst_ptr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rf_di     (rf_di),
        .rf_ptr_w  (rf_ptr_w),
        .rf_we     (rf_we),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // One transaction: request in cycle 0, memory ack in cycle lat (mem_req
    // starts in cycle 1, so lat=1 acks the first request cycle).
    typedef struct packed {
        bit         ld;
        bit         st;
        logic [7:0] a;
        logic [7:0] d;
        logic [4:0] p;
        int         lat;
        logic [7:0] rd;
    } txn_t;

    // Observed/expected summary over the transaction window; *_c are cycle
    // numbers relative to the request cycle.
    typedef struct packed {
        int         req_n;
        int         busy_n;
        int         done_n;
        int         done_c;
        int         err_n;
        int         err_c;
        int         we_n;
        int         we_c;
        logic [7:0] di;
        logic [4:0] ptr;
        int         hold;
    } res_t;

    typedef struct {
        string name;
        txn_t  t;
        res_t  e;
    } vec_t;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int act, int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endfunction

    // Reference: timing and outcome derived directly from the access rules.
    function automatic res_t model(txn_t t);
        res_t r;
        bit   acked;
        bit   is_ld;
        int   rc;
        r     = '0;
        acked = (t.lat >= 1) && (t.lat <= TO);
        is_ld = !t.st;
        rc    = acked ? t.lat : TO;
        r.req_n  = rc;
        r.busy_n = rc + ((acked && is_ld) ? 1 : 0);
        r.done_n = acked ? 1 : 0;
        r.done_c = rc + (is_ld ? 2 : 1);
        r.err_n  = (acked ? 0 : 1) + ((t.ld && t.st) ? 1 : 0);
        r.err_c  = (t.ld && t.st) ? 1 : TO + 1;
        r.we_n   = (acked && is_ld && t.p != 5'd0) ? 1 : 0;
        r.we_c   = rc + 2;
        r.di     = t.rd;
        r.ptr    = t.p;
        return r;
    endfunction

    task automatic run_txn(input txn_t t, output res_t o);
        o = '0;
        for (int c = 0; c <= WIN; c++) begin
            if (mem_req) begin
                o.req_n++;
                if (mem_wr !== t.st) o.hold++;
                if (mem_addr !== t.a) o.hold++;
                if (t.st && mem_wdata !== t.d) o.hold++;
            end
            if (busy) o.busy_n++;
            if (done) begin o.done_n++; o.done_c = c; end
            if (err) begin
                o.err_n++;
                if (o.err_n == 1) o.err_c = c;
            end
            if (rf_we) begin
                o.we_n++; o.we_c = c; o.di = rf_di; o.ptr = rf_ptr_w;
            end
            ld_req    = (c == 0) && t.ld;
            st_req    = (c == 0) && t.st;
            addr      = (c == 0) ? t.a : 8'($urandom);
            st_data   = (c == 0) ? t.d : 8'($urandom);
            dst_ptr   = (c == 0) ? t.p : 5'($urandom);
            mem_ack   = (c == t.lat);
            mem_rdata = (c == t.lat) ? t.rd : 8'($urandom);
            @(negedge clk);
        end
        ld_req  = 1'b0;
        st_req  = 1'b0;
        mem_ack = 1'b0;
    endtask

    function automatic void cmp(string nm, res_t o, res_t e);
        chk({nm, ".req_cycles"},  o.req_n,  e.req_n);
        chk({nm, ".busy_cycles"}, o.busy_n, e.busy_n);
        chk({nm, ".done_count"},  o.done_n, e.done_n);
        if (e.done_n > 0) chk({nm, ".done_cycle"}, o.done_c, e.done_c);
        chk({nm, ".err_count"},   o.err_n,  e.err_n);
        if (e.err_n > 0) chk({nm, ".err_cycle"}, o.err_c, e.err_c);
        chk({nm, ".we_count"},    o.we_n,   e.we_n);
        if (e.we_n > 0) begin
            chk({nm, ".we_cycle"}, o.we_c, e.we_c);
            chk({nm, ".rf_di"},    int'(o.di),  int'(e.di));
            chk({nm, ".rf_ptr_w"}, int'(o.ptr), int'(e.ptr));
        end
        chk({nm, ".hold_violations"}, o.hold, 0);
    endfunction

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t o;
        txn_t t;

        //                 name               ld st  a      d      p     lat  rd        req busy dn dc er ec we wc di     ptr hold
        vecs[0] = '{"store_lat3",  '{0, 1, 8'h10, 8'hA5, 5'd0,  3,  8'h00}, '{ 3,  3, 1,  4, 0,  0, 0,  0, 8'h00, 5'd0,  0}};
        vecs[1] = '{"load_lat1",   '{1, 0, 8'h20, 8'h00, 5'd3,  1,  8'h5C}, '{ 1,  2, 1,  3, 0,  0, 1,  3, 8'h5C, 5'd3,  0}};
        vecs[2] = '{"load_timeout",'{1, 0, 8'h30, 8'h00, 5'd7,  18, 8'h99}, '{16, 16, 0,  0, 1, 17, 0,  0, 8'h00, 5'd0,  0}};
        vecs[3] = '{"load_r0",     '{1, 0, 8'h44, 8'h00, 5'd0,  2,  8'hFF}, '{ 2,  3, 1,  4, 0,  0, 0,  0, 8'h00, 5'd0,  0}};
        vecs[4] = '{"ld_st_both",  '{1, 1, 8'h50, 8'h33, 5'd9,  2,  8'h00}, '{ 2,  2, 1,  3, 1,  1, 0,  0, 8'h00, 5'd0,  0}};
        vecs[5] = '{"load_ack_at_to",'{1, 0, 8'h60, 8'h00, 5'd12, 16, 8'hC3}, '{16, 17, 1, 18, 0,  0, 1, 18, 8'hC3, 5'd12, 0}};
        vecs[6] = '{"store_ack_late",'{0, 1, 8'h70, 8'h11, 5'd0, 17, 8'h00}, '{16, 16, 0,  0, 1, 17, 0,  0, 8'h00, 5'd0,  0}};

        reset = 1'b0; ld_req = 1'b0; st_req = 1'b0; addr = '0; st_data = '0;
        dst_ptr = '0; mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("reset.ctrl_outputs", int'({busy, done, err, rf_we, mem_req, mem_wr}), 0);
        chk("reset.data_outputs", int'({mem_addr, mem_wdata, rf_di, rf_ptr_w}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i].t, o);
            cmp(vecs[i].name, o, vecs[i].e);
        end

        // Back-to-back: a request during busy is ignored; one in the first
        // idle cycle after a store's done is accepted.
        for (int c = 0; c <= 7; c++) begin
            chk($sformatf("b2b.mem_req.c%0d", c), int'(mem_req), int'(c == 1 || c == 3));
            chk($sformatf("b2b.done.c%0d", c),    int'(done),    int'(c == 2 || c == 5));
            chk($sformatf("b2b.rf_we.c%0d", c),   int'(rf_we),   int'(c == 5));
            chk($sformatf("b2b.busy.c%0d", c),    int'(busy),    int'(c == 1 || c == 3 || c == 4));
            if (c == 1) chk("b2b.store_addr", int'({mem_wr, mem_addr}), int'({1'b1, 8'h90}));
            if (c == 3) chk("b2b.load_addr",  int'({mem_wr, mem_addr}), int'({1'b0, 8'h40}));
            if (c == 5) chk("b2b.wb_data",    int'({rf_di, rf_ptr_w}),  int'({8'h77, 5'd5}));
            st_req    = (c == 0);
            ld_req    = (c == 1 || c == 2);
            addr      = (c == 0) ? 8'h90 : 8'h40;
            st_data   = 8'h5A;
            dst_ptr   = 5'd5;
            mem_ack   = (c == 1 || c == 3);
            mem_rdata = (c == 3) ? 8'h77 : 8'($urandom);
            @(negedge clk);
        end
        ld_req = 1'b0; st_req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an access drops everything without a clock.
        ld_req = 1'b1; addr = 8'h80; dst_ptr = 5'd4;
        @(negedge clk);
        ld_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.pre_req_busy", int'({mem_req, busy}), 3);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.req_busy_we", int'({mem_req, busy, rf_we}), 0);
        chk("rst_mid.done_err",    int'({done, err}), 0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 4; c++) begin
                if (done || err || busy) pulses++;
                mem_ack = (c == 1);
                @(negedge clk);
            end
            mem_ack = 1'b0;
            chk("rst_mid.after_release_quiet", pulses, 0);
        end
        t = '{1, 0, 8'h81, 8'h00, 5'd6, 2, 8'h3E};
        run_txn(t, o);
        cmp("rst_mid.fresh_load", o, model(t));

        // Randomized transactions against the reference model.
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind  = $urandom_range(0, 3);
            t.ld  = (kind != 2);
            t.st  = (kind >= 2);
            t.a   = 8'($urandom);
            t.d   = 8'($urandom);
            t.p   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            t.lat = $urandom_range(1, TO + 3);
            t.rd  = 8'($urandom);
            run_txn(t, o);
            cmp($sformatf("rand%0d", n), o, model(t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
